// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC + single-outstanding imem reader feeding a small {pc, word} prefetch FIFO
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] instruction,
   output logic [31:0] instr_pc,
   output logic        instr_valid
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] WAIT  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   logic [1:0]    state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   drain_addr_q, last_pc_q;
   logic [31:0]   pc_mem_q   [DEPTH];
   logic [31:0]   word_mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          take, pop, push, issue;
   // handshake qualifiers; redirect overrides every FIFO movement
   always_comb begin
      take  = instr_valid & ~stall;
      pop   = take & ~redirect_valid;
      push  = (state_q == WAIT) & imem_rvalid & ~redirect_valid;
      issue = (state_q == IDLE) & ~redirect_valid & ((count_q - CW'(take)) < FULL);
   end
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end
   // next state: any response ends the transaction, redirect in WAIT turns it into a discard
   always_comb begin
      state_d = (state_q == IDLE) ? (issue ? WAIT : IDLE)
              : imem_rvalid ? IDLE
              : (state_q == WAIT && redirect_valid) ? DRAIN : state_q;
   end
   // outputs: DRAIN keeps presenting the abandoned address until its response arrives
   always_comb begin
      imem_req    = state_q != IDLE;
      imem_addr   = (state_q == DRAIN) ? drain_addr_q : fetch_pc_q;
      instr_valid = count_q != '0;
      instruction = instr_valid ? word_mem_q[rd_ptr_q] : NOP;
      instr_pc    = instr_valid ? pc_mem_q[rd_ptr_q] : last_pc_q;
   end
   // next fetch PC and occupancy
   always_comb begin
      fetch_pc_d = redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : push ? fetch_pc_q + 32'd4 : fetch_pc_q;
      count_d    = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
   end
   // PC, pointers and occupancy registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q   <= RESET_PC;
         drain_addr_q <= RESET_PC;
         last_pc_q    <= RESET_PC;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         drain_addr_q <= (state_q == WAIT) ? fetch_pc_q : drain_addr_q;
         last_pc_q    <= instr_pc;
         rd_ptr_q     <= redirect_valid ? '0 : rd_ptr_q + PW'(pop);
         wr_ptr_q     <= redirect_valid ? '0 : wr_ptr_q + PW'(push);
         count_q      <= count_d;
      end
   end
   // FIFO storage needs no reset; occupancy qualifies every read
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]   <= imem_addr;
         word_mem_q[wr_ptr_q] <= imem_rdata;
      end
   end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch, stall, redirect, PC wrap and async reset
module tb_instr_fetch_unit;
   logic        clk = 0;
   logic        rst_n, stall, redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req, imem_rvalid, instr_valid;
   logic [31:0] imem_addr, imem_rdata, instruction, instr_pc;
   logic        mem_en, mem_rvalid, man_rvalid;
   logic [31:0] mem_rdata, man_rdata;
   int          lat, wcnt;
   logic        w_req, w_rvalid, w_valid;
   logic [31:0] w_addr, w_instr, w_pc;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   assign imem_rvalid = mem_en ? mem_rvalid : man_rvalid;
   assign imem_rdata  = mem_en ? mem_rdata : man_rdata;

   instr_fetch_unit u_dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid)
   );

   instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
      .imem_rvalid(w_rvalid), .imem_rdata(w_addr ^ 32'hA5A5_0000), .stall(1'b0),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .instruction(w_instr), .instr_pc(w_pc), .instr_valid(w_valid)
   );

   // memory answering lat cycles after the request edge, data = addr ^ A5A5_0000
   always @(negedge clk) begin
      mem_rvalid = 1'b0;
      if (!mem_en || !imem_req) wcnt = 0;
      else if (wcnt == lat - 1) begin
         mem_rvalid = 1'b1;
         mem_rdata  = imem_addr ^ 32'hA5A5_0000;
         wcnt       = 0;
      end else wcnt = wcnt + 1;
   end

   // single-cycle memory for the wrap instance
   always @(negedge clk) w_rvalid = w_req && !w_rvalid;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      w_rvalid = 0; mem_rvalid = 0; mem_rdata = 0; wcnt = 0;
      rst_n = 0; stall = 0; redirect_valid = 0; redirect_pc = 0;
      lat = 1; mem_en = 1; man_rvalid = 0; man_rdata = 0;
      // reset values, then free-run with 1-cycle memory
      step(2);
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_instr", instruction, 32'h13);
      chk("rst_pc", instr_pc, 0);
      rst_n = 1;
      step;
      chk("e1_req", imem_req, 1);
      chk("e1_addr", imem_addr, 0);
      chk("e1_valid", instr_valid, 0);
      step;
      chk("e2_valid", instr_valid, 1);
      chk("e2_pc", instr_pc, 0);
      chk("e2_instr", instruction, 32'hA5A5_0000);
      chk("e2_req", imem_req, 0);
      chk("wrap_pc0", w_pc, 32'hFFFF_FFFC);
      chk("wrap_instr0", w_instr, 32'h5A5A_FFFC);
      step;
      chk("e3_valid", instr_valid, 0);
      chk("e3_addr", imem_addr, 4);
      chk("e3_lastpc", instr_pc, 0);
      step;
      chk("e4_pc", instr_pc, 4);
      chk("e4_instr", instruction, 32'hA5A5_0004);
      chk("wrap_pc1", w_pc, 0);
      chk("wrap_instr1", w_instr, 32'hA5A5_0000);
      // stall from reset: FIFO fills to two entries and requests stop
      rst_n = 0; stall = 1;
      step;
      rst_n = 1;
      step(10);
      chk("stall_req", imem_req, 0);
      chk("stall_addr", imem_addr, 8);
      chk("stall_pc", instr_pc, 0);
      chk("stall_instr", instruction, 32'hA5A5_0000);
      stall = 0;
      step;
      chk("rel_pc4", instr_pc, 4);
      chk("rel_req", imem_req, 1);
      chk("rel_addr", imem_addr, 8);
      step;
      chk("rel_pc8", instr_pc, 8);
      chk("rel_instr8", instruction, 32'hA5A5_0008);
      // redirect while WAIT with 3-cycle memory
      rst_n = 0; lat = 3;
      step;
      rst_n = 1;
      step;
      redirect_valid = 1; redirect_pc = 32'h0000_0103;
      step;
      redirect_valid = 0;
      chk("drain_req", imem_req, 1);
      chk("drain_addr", imem_addr, 0);
      step(2);
      chk("drop_valid", instr_valid, 0);
      chk("drop_req", imem_req, 0);
      step;
      chk("redir_req", imem_req, 1);
      chk("redir_addr", imem_addr, 32'h100);
      step(3);
      chk("redir_valid", instr_valid, 1);
      chk("redir_pc", instr_pc, 32'h100);
      chk("redir_instr", instruction, 32'hA5A5_0100);
      // redirect coinciding with a response and a pop
      rst_n = 0; stall = 1; lat = 1;
      step;
      rst_n = 1;
      step(3);
      chk("co_pre_pc", instr_pc, 0);
      chk("co_pre_addr", imem_addr, 4);
      stall = 0; redirect_valid = 1; redirect_pc = 32'h0000_0040;
      step;
      redirect_valid = 0;
      chk("co_valid", instr_valid, 0);
      chk("co_req", imem_req, 0);
      chk("co_addr", imem_addr, 32'h40);
      chk("co_lastpc", instr_pc, 0);
      step;
      chk("co_req2", imem_req, 1);
      chk("co_addr2", imem_addr, 32'h40);
      step;
      chk("co_pc", instr_pc, 32'h40);
      chk("co_instr", instruction, 32'hA5A5_0040);
      // async reset mid-WAIT and a spurious response right after release
      rst_n = 0;
      step;
      rst_n = 1;
      step(3);
      chk("ar_pre_addr", imem_addr, 4);
      mem_en = 0;
      #2 rst_n = 0;
      #1;
      chk("ar_req", imem_req, 0);
      chk("ar_addr", imem_addr, 0);
      chk("ar_valid", instr_valid, 0);
      chk("ar_instr", instruction, 32'h13);
      @(posedge clk);
      #1;
      rst_n = 1; man_rvalid = 1; man_rdata = 32'hDEAD_BEEF;
      step;
      man_rvalid = 0;
      chk("sp_valid", instr_valid, 0);
      chk("sp_req", imem_req, 1);
      chk("sp_addr", imem_addr, 0);
      mem_en = 1;
      step;
      chk("sp_pc", instr_pc, 0);
      chk("sp_instr", instruction, 32'hA5A5_0000);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
